// File: rtl/seg_pkg.sv
// seg_pkg: shared constants for the 7-segment scanner
package seg_pkg;
    localparam int DIG_W = 2;
    localparam logic [3:0] AN_OFF = 4'b1111;
    localparam logic [7:0] HEX_OFF = 8'hFF;
    // Active-low gfedcba patterns, index 15 first so SEG_TBL[n] is nibble n
    localparam logic [15:0][6:0] SEG_TBL = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };
endpackage

// File: rtl/seg_scan_hex7seg.sv
// hex7seg: nibble to active-low gfedcba segment decoder
module hex7seg
    import seg_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);
    assign o_seg = SEG_TBL[i_nib];
endmodule

// File: rtl/seg_scan.sv
// seg_scan: word select/freeze and 4-digit multiplexed 7-segment scanner
module seg_scan
    import seg_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int BLANK    = 16
) (
    input  logic        CLK,
    input  logic        RSTN,
    input  logic [15:0] seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7,
    input  logic [15:0] seg8, seg9, sega, segb, segc, segd, sege, segf,
    input  logic [7:0]  led_in,
    input  logic [3:0]  sel,
    input  logic        hold,
    output logic [3:0]  an,
    output logic [7:0]  hex,
    output logic [3:0]  phase_led
);
    logic [15:0]      w_words [16];
    logic [15:0]      r_p;
    logic [DIG_W-1:0] r_digit;
    logic [15:0]      r_disp;
    logic             w_last;
    logic             w_blank;
    logic [3:0]       w_nib;
    logic [6:0]       w_seg;
    logic             w_unused;

    assign w_words  = '{seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7,
                        seg8, seg9, sega, segb, segc, segd, sege, segf};
    assign w_last   = r_p == 16'(SCAN_DIV - 1);
    assign w_blank  = r_p < 16'(BLANK);
    assign w_nib    = r_disp[{r_digit, 2'b00} +: 4];
    assign w_unused = &{1'b0, led_in[7:4]};

    hex7seg u_dec (.i_nib(w_nib), .o_seg(w_seg));

    // Slot prescaler; the digit advances on the last cycle of each slot
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_p     <= '0;
            r_digit <= '0;
        end else begin
            r_p     <= w_last ? '0 : r_p + 16'd1;
            r_digit <= w_last ? r_digit + 1'b1 : r_digit;
        end
    end

    // Snapshot of the selected word, frozen while hold is high
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) r_disp <= '0;
        else if (!hold) r_disp <= w_words[sel];
    end

    // Registered display drive; blanking at slot start suppresses ghosting
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            an        <= AN_OFF;
            hex       <= HEX_OFF;
            phase_led <= '0;
        end else begin
            an        <= w_blank ? AN_OFF : ~(4'b0001 << r_digit);
            hex       <= w_blank ? HEX_OFF : {~(hold && r_digit == '0), w_seg};
            phase_led <= led_in[3:0];
        end
    end
endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan: randomized scanner bench against a slot-arithmetic reference model
module tb_seg_scan;
    logic        CLK = 0;
    logic        RSTN = 0;
    logic [15:0] words [16];
    logic [7:0]  led_in = 0;
    logic [3:0]  sel = 0;
    logic        hold = 0;
    logic [3:0]  an, an2;
    logic [7:0]  hex, hex2;
    logic [3:0]  ph, ph2;
    int checks = 0;
    int errors = 0;

    localparam logic [6:0] TBL [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    always #5 CLK = ~CLK;

    seg_scan #(.SCAN_DIV(4), .BLANK(1)) u_dut (
        .CLK(CLK), .RSTN(RSTN),
        .seg0(words[0]), .seg1(words[1]), .seg2(words[2]), .seg3(words[3]),
        .seg4(words[4]), .seg5(words[5]), .seg6(words[6]), .seg7(words[7]),
        .seg8(words[8]), .seg9(words[9]), .sega(words[10]), .segb(words[11]),
        .segc(words[12]), .segd(words[13]), .sege(words[14]), .segf(words[15]),
        .led_in(led_in), .sel(sel), .hold(hold), .an(an), .hex(hex), .phase_led(ph));

    seg_scan #(.SCAN_DIV(2), .BLANK(0)) u_dut2 (
        .CLK(CLK), .RSTN(RSTN),
        .seg0(words[0]), .seg1(words[1]), .seg2(words[2]), .seg3(words[3]),
        .seg4(words[4]), .seg5(words[5]), .seg6(words[6]), .seg7(words[7]),
        .seg8(words[8]), .seg9(words[9]), .sega(words[10]), .segb(words[11]),
        .segc(words[12]), .segd(words[13]), .sege(words[14]), .segf(words[15]),
        .led_in(led_in), .sel(sel), .hold(hold), .an(an2), .hex(hex2), .phase_led(ph2));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // What the display must show n cycles after reset release, from the slot rules
    function automatic logic [11:0] expect_out(input int n, input int sd, input int bl,
                                               input logic [15:0] dsp, input logic h);
        int p, d;
        logic [3:0] a;
        logic [15:0] sh;
        p = n % sd;
        d = (n / sd) % 4;
        if (p < bl) return {4'hF, 8'hFF};
        a = 4'hF;
        a[d] = 1'b0;
        sh = dsp >> (4 * d);
        return {a, ~(h && d == 0), TBL[sh[3:0]]};
    endfunction

    int n0, n1;
    logic [15:0] md0, md1;
    logic [11:0] e0, e1;
    logic [3:0]  eph;

    always @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            n0 = 0; n1 = 0; md0 = 0; md1 = 0;
            e0 = {4'hF, 8'hFF}; e1 = {4'hF, 8'hFF}; eph = 0;
        end else begin
            e0 = expect_out(n0, 4, 1, md0, hold);
            e1 = expect_out(n1, 2, 0, md1, hold);
            eph = led_in[3:0];
            if (!hold) begin
                md0 = words[sel];
                md1 = words[sel];
            end
            n0++;
            n1++;
        end
    end

    always @(posedge CLK) begin
        #1;
        chk("an", an, e0[11:8]);
        chk("hex", hex, e0[7:0]);
        chk("phase_led", ph, eph);
        chk("an2", an2, e1[11:8]);
        chk("hex2", hex2, e1[7:0]);
        chk("phase_led2", ph2, eph);
        chk("an_onehot", 32'($countones(~an) <= 1), 1);
        if (RSTN && n1 >= 2) chk("an2_never_off", 32'(an2 != 4'hF), 1);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16; i++) words[i] = 16'h0;
        repeat (3) @(negedge CLK);
        chk("reset_an", an, 4'hF);
        chk("reset_hex", hex, 8'hFF);
        chk("reset_ph", ph, 4'h0);
        words[3] = 16'h1A2F;
        sel = 3;
        RSTN = 1;
        tick();
        chk("t1_blank_an", an, 4'hF);
        tick();
        chk("t1_s0_an", an, 4'b1110);
        chk("t1_s0_hex", hex, 8'h8E);
        repeat (4) tick();
        chk("t1_s1_an", an, 4'b1101);
        chk("t1_s1_hex", hex, 8'hA4);
        repeat (4) tick();
        chk("t1_s2_an", an, 4'b1011);
        chk("t1_s2_hex", hex, 8'h88);
        repeat (4) tick();
        chk("t1_s3_an", an, 4'b0111);
        chk("t1_s3_hex", hex, 8'hF9);
        // Random traffic
        for (int k = 0; k < 300; k++) begin
            @(negedge CLK);
            words[$urandom_range(0, 15)] = 16'($urandom);
            sel = 4'($urandom);
            hold = ($urandom_range(0, 3) == 0);
            led_in = 8'($urandom);
        end
        // Hold freezes the shown word
        @(negedge CLK);
        hold = 0; sel = 5; words[5] = 16'h0000;
        repeat (2) @(negedge CLK);
        hold = 1;
        @(negedge CLK);
        words[5] = 16'hFFFF; sel = 7; words[7] = 16'h1234;
        for (int k = 0; k < 16; k++) begin
            tick();
            if (an == 4'b1110) chk("hold_dp_digit0", hex, 8'h40);
            else if (an != 4'hF) chk("hold_digit", hex, 8'hC0);
        end
        @(negedge CLK);
        hold = 0;
        repeat (2) tick();
        for (int k = 0; k < 16; k++) begin
            tick();
            if (an == 4'b1110) chk("release_digit0", hex, 8'h99);
        end
        // Decode sweep on digit 0
        sel = 0;
        for (int v = 0; v < 16; v++) begin
            @(negedge CLK);
            words[0] = {12'h0, 4'(v)};
            repeat (16) tick();
        end
        // Asynchronous reset mid-slot at p=2, digit=2
        for (int k = 0; k < 40 && (n0 % 16) != 10; k++) tick();
        chk("reach_p2_d2", 32'(n0 % 16), 10);
        #2 RSTN = 0;
        #1;
        chk("async_an", an, 4'hF);
        chk("async_hex", hex, 8'hFF);
        chk("async_an2", an2, 4'hF);
        @(negedge CLK);
        RSTN = 1;
        tick();
        chk("post_reset_blank", an, 4'hF);
        tick();
        chk("post_reset_d0", an, 4'b1110);
        // Phase LED
        @(negedge CLK);
        led_in = 8'hA4;
        tick();
        chk("led_a4", ph, 4'h4);
        @(negedge CLK);
        led_in = 8'h08;
        tick();
        chk("led_08", ph, 4'h8);
        repeat (4) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
